// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier datapath.
// Accumulator width, shift clamp and the accumulator FSM encoding.
package mul_pkg;

   localparam int ACC_W     = 64;
   localparam int MAX_SHIFT = 32;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      RESOLVE,
      DONE
   } state_t;

   // Row shifts above MAX_SHIFT saturate at MAX_SHIFT.
   function automatic logic [5:0] clamp_shift(input logic [5:0] sh);
      return (sh > 6'(MAX_SHIFT)) ? 6'(MAX_SHIFT) : sh;
   endfunction

endpackage

// File: rtl/csa_3_2.sv
// Parametric-width 3:2 carry-save compressor.
// The carry output is already weighted (shifted left one, top bit dropped).
module csa_3_2 #(
   parameter int W = 64
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic [W-1:0] i_c,
   output logic [W-1:0] o_sum,
   output logic [W-1:0] o_carry
);

   assign o_sum   = i_a ^ i_b ^ i_c;
   assign o_carry = ((i_a & i_b) | (i_a & i_c) | (i_b & i_c)) << 1;

endmodule

// File: rtl/csa_accumulator.sv
// Carry-save accumulator for reducer row triples.
// Folds triples 5:2 into sum/carry, then resolves with a chunked CPA.
module csa_accumulator
   import mul_pkg::*;
#(
   parameter int CPA_W = 16
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        start,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_last,
   input  logic [5:0]  in_shift,
   input  logic [31:0] in_row1,
   input  logic [32:0] in_row2,
   input  logic [33:0] in_row3,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] result,
   output logic        busy
);

   localparam int NCH = ACC_W / CPA_W;
   localparam int CW  = $clog2(NCH + 1);

   state_t r_state;
   state_t w_next;

   logic [ACC_W-1:0] r_sum;
   logic [ACC_W-1:0] r_carry;
   logic [ACC_W-1:0] r_result;
   logic [CW-1:0]    r_chunk;
   logic             r_cin;

   logic             w_accept;
   logic             w_hs;
   logic             w_clear;
   logic             w_chunk_end;
   logic [5:0]       w_sh;
   logic [ACC_W-1:0] w_r1;
   logic [ACC_W-1:0] w_r2;
   logic [ACC_W-1:0] w_r3;
   logic [ACC_W-1:0] w_s1;
   logic [ACC_W-1:0] w_c1;
   logic [ACC_W-1:0] w_s2;
   logic [ACC_W-1:0] w_c2;
   logic [ACC_W-1:0] w_s3;
   logic [ACC_W-1:0] w_c3;
   logic [31:0]      w_off;
   logic [CPA_W-1:0] w_a;
   logic [CPA_W-1:0] w_b;
   logic [CPA_W-1:0] w_chunk;
   logic             w_cout;
   logic [ACC_W-1:0] w_mask;
   logic [ACC_W-1:0] w_ins;

   assign in_ready  = (r_state == ACCUM);
   assign out_valid = (r_state == DONE);
   assign busy      = (r_state != IDLE);
   assign result    = r_result;

   assign w_accept    = in_valid & in_ready;
   assign w_hs        = out_valid & out_ready;
   assign w_clear     = start & ((r_state == IDLE) |
                                 ((r_state == DONE) & w_hs));
   assign w_chunk_end = (r_chunk == CW'(NCH));

   assign w_sh = clamp_shift(in_shift);
   assign w_r1 = ACC_W'(in_row1) << w_sh;
   assign w_r2 = ACC_W'(in_row2) << w_sh;
   assign w_r3 = ACC_W'(in_row3) << w_sh;

   csa_3_2 #(.W(ACC_W)) u_l1 (
      .i_a     (r_sum),
      .i_b     (r_carry),
      .i_c     (w_r1),
      .o_sum   (w_s1),
      .o_carry (w_c1)
   );

   csa_3_2 #(.W(ACC_W)) u_l2 (
      .i_a     (w_s1),
      .i_b     (w_c1),
      .i_c     (w_r2),
      .o_sum   (w_s2),
      .o_carry (w_c2)
   );

   csa_3_2 #(.W(ACC_W)) u_l3 (
      .i_a     (w_s2),
      .i_b     (w_c2),
      .i_c     (w_r3),
      .o_sum   (w_s3),
      .o_carry (w_c3)
   );

   // One CPA chunk per RESOLVE cycle, selected by the chunk counter.
   always_comb begin
      w_off  = 32'(r_chunk) * CPA_W;
      w_a    = CPA_W'(r_sum >> w_off);
      w_b    = CPA_W'(r_carry >> w_off);
      {w_cout, w_chunk} = {1'b0, w_a} + {1'b0, w_b} + (CPA_W + 1)'(r_cin);
      w_mask = ACC_W'({CPA_W{1'b1}}) << w_off;
      w_ins  = ACC_W'(w_chunk) << w_off;
   end

   // Next-state logic for the accumulate/resolve/handoff sequence.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start) w_next = ACCUM;
         ACCUM:   if (w_accept && in_last) w_next = RESOLVE;
         RESOLVE: if (w_chunk_end) w_next = DONE;
         DONE:    if (w_hs) w_next = start ? ACCUM : IDLE;
         default: w_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Carry-save accumulator: cleared on start, folded on each accept.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_sum   <= '0;
         r_carry <= '0;
      end else if (w_clear) begin
         r_sum   <= '0;
         r_carry <= '0;
      end else if (w_accept) begin
         r_sum   <= w_s3;
         r_carry <= w_c3;
      end
   end

   // Chunked resolve: write one result slice per cycle, ripple the carry.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_result <= '0;
         r_chunk  <= '0;
         r_cin    <= 1'b0;
      end else if (r_state == RESOLVE) begin
         if (!w_chunk_end) begin
            r_result <= (r_result & ~w_mask) | w_ins;
            r_cin    <= w_cout;
            r_chunk  <= r_chunk + CW'(1);
         end
      end else begin
         r_chunk <= '0;
         r_cin   <= 1'b0;
      end
   end

endmodule
